// File: rtl/ut_mul_pkg.sv
// Shared types and helpers for the unary-temporal multiply sequencer.
// Optional zero-operand skip is enabled by defining UT_ZERO_SKIP_EN.
package ut_mul_pkg;

  localparam int UT_WIDTH = 16;
  localparam int MAG_W    = UT_WIDTH - 1;
  localparam int ACC_W    = UT_WIDTH;
  localparam int UT_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } state_t;

  function automatic logic [MAG_W-1:0] bitrev(input logic [MAG_W-1:0] v);
    return {<<{v}};
  endfunction

  // Stream length can never exceed the magnitude precision.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/ut_rng_bitrev.sv
// Counter plus bit-reversal sequence generator with registered output.
// Kept as its own block so a Sobol generator can replace it later.
module ut_rng_bitrev #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] rand_val
);

  logic [W-1:0] ctr_reg;
  logic [W-1:0] rand_reg;
  logic [W-1:0] rev;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign rev[gi] = ctr_reg[W-1-gi];
    end
  endgenerate

  // Clear presents bitrev(0) and preloads 1, so the output leads the
  // sequencer's run counter by one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_reg  <= '0;
      rand_reg <= '0;
    end else if (clear) begin
      ctr_reg  <= W'(1);
      rand_reg <= '0;
    end else if (en) begin
      ctr_reg  <= ctr_reg + W'(1);
      rand_reg <= rev;
    end
  end

  assign rand_val = rand_reg;

endmodule

// File: rtl/ut_mul_seq.sv
// Sequencer for one unary-temporal sign-magnitude multiply on a single PE.
// Define UT_ZERO_SKIP_EN to bypass the stream when either magnitude is zero.
module ut_mul_seq
  import ut_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_i,
  input  logic [WIDTH-1:0] i_data_w,
  input  logic [LEN_W-1:0] i_len_log,
  output logic             o_bit_i,
  output logic [WIDTH-2:0] o_data_w,
  output logic [WIDTH-2:0] o_randW,
  input  logic             i_bit_o,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_prod,
  output logic             o_busy
);

  localparam int MW = WIDTH - 1;
  localparam int AW = WIDTH;

  state_t           state_reg, state_next;
  logic [MW-1:0]    mi_reg, mw_reg;
  logic             sgn_reg;
  logic [LEN_W-1:0] len_reg;
  logic [MW-1:0]    cnt_reg;
  logic [AW-1:0]    acc_reg;

  logic             accept;
  logic [LEN_W-1:0] len_in;
  logic [LEN_W-1:0] shamt;
  logic [MW-1:0]    thr;
  logic [MW:0]      run_len;
  logic             run_last;
  logic [AW+MW-1:0] acc_shift;
  logic [MW-1:0]    mag;

  assign accept   = i_valid && (state_reg == IDLE);
  assign len_in   = LEN_W'(clamp_len(int'(i_len_log), MW));
  assign shamt    = LEN_W'(MW) - len_reg;
  assign thr      = mi_reg >> shamt;
  assign run_len  = (MW+1)'(1) << len_reg;
  assign run_last = ({1'b0, cnt_reg} == (run_len - (MW+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mi_reg    <= '0;
      mw_reg    <= '0;
      sgn_reg   <= 1'b0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mi_reg  <= i_data_i[MW-1:0];
        mw_reg  <= i_data_w[MW-1:0];
        sgn_reg <= i_data_i[WIDTH-1] ^ i_data_w[WIDTH-1];
        len_reg <= len_in;
        cnt_reg <= '0;
        acc_reg <= '0;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + MW'(1);
        acc_reg <= acc_reg + AW'(i_bit_o);
      end
    end
  end

`ifdef UT_ZERO_SKIP_EN
  logic zero_ops;
  assign zero_ops = (i_data_i[MW-1:0] == '0) || (i_data_w[MW-1:0] == '0);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
`ifdef UT_ZERO_SKIP_EN
          state_next = zero_ops ? DONE : PRIME;
`else
          state_next = PRIME;
`endif
        end
      end
      PRIME:   state_next = RUN;
      RUN:     if (run_last) state_next = DONE;
      DONE:    if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The scaled count can in principle exceed the magnitude range; clip it.
  assign acc_shift = {{MW{1'b0}}, acc_reg} << shamt;
  assign mag       = (|acc_shift[AW+MW-1:MW]) ? {MW{1'b1}} : acc_shift[MW-1:0];

  assign o_ready  = (state_reg == IDLE);
  assign o_valid  = (state_reg == DONE);
  assign o_busy   = (state_reg == PRIME) || (state_reg == RUN);
  assign o_bit_i  = (state_reg == RUN) && (cnt_reg < thr);
  assign o_data_w = (state_reg == IDLE) ? '0 : mw_reg;
  assign o_prod   = (state_reg == DONE) ? {sgn_reg && (mag != '0), mag} : '0;

  ut_rng_bitrev #(.W(MW)) u_rng (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .en       (o_busy),
    .rand_val (o_randW)
  );

endmodule

// File: tb/tb_ut_mul_seq.sv
// Self-checking bench for ut_mul_seq with a behavioural PE attached.
module tb_ut_mul_seq;
  import ut_mul_pkg::*;

  localparam int LIMIT = 40000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data_i;
  logic [15:0] i_data_w;
  logic [3:0]  i_len_log;
  logic        o_bit_i;
  logic [14:0] o_data_w;
  logic [14:0] o_randW;
  logic        i_bit_o;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_prod;
  logic        o_busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] di;
    logic [15:0] dw;
    logic [3:0]  ln;
    logic [15:0] prod;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  ut_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data_i  (i_data_i),
    .i_data_w  (i_data_w),
    .i_len_log (i_len_log),
    .o_bit_i   (o_bit_i),
    .o_data_w  (o_data_w),
    .o_randW   (o_randW),
    .i_bit_o   (i_bit_o),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_prod    (o_prod),
    .o_busy    (o_busy)
  );

  // PE model: registers the random value, emits bit_i AND (rand < weight).
  logic [14:0] pe_rand_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe_rand_reg <= '0;
    else        pe_rand_reg <= o_randW;
  end
  assign i_bit_o = o_bit_i & (pe_rand_reg < o_data_w);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_prod(input logic [15:0] di, input logic [15:0] dw,
                                           input logic [3:0] ln);
    int l, mi, mw, thr, acc, m;
    l   = (ln > 4'd15) ? 15 : int'(ln);
    mi  = int'(di[14:0]);
    mw  = int'(dw[14:0]);
    thr = mi >> (15 - l);
    acc = 0;
    for (int c = 0; c < (1 << l); c++)
      if (c < thr && int'(bitrev(15'(c))) < mw) acc++;
    m = acc << (15 - l);
    if (m > 32767) m = 32767;
    return {(di[15] ^ dw[15]) && (m != 0), 15'(m)};
  endfunction

  task automatic do_op(input logic [15:0] di, input logic [15:0] dw, input logic [3:0] ln,
                       input logic [15:0] exp, input int hold);
    int lat, busy, exp_lat, exp_busy, l;
    logic dw_ok, hold_ok, zero;
    logic [15:0] first, expq;
    l    = (ln > 4'd15) ? 15 : int'(ln);
    zero = (di[14:0] == 15'd0) || (dw[14:0] == 15'd0);
`ifdef UT_ZERO_SKIP_EN
    exp_lat  = zero ? 1 : (1 << l) + 2;
    exp_busy = zero ? 0 : (1 << l) + 1;
`else
    exp_lat  = (1 << l) + 2;
    exp_busy = (1 << l) + 1;
`endif
    @(negedge clk);
    i_valid = 1'b1; i_data_i = di; i_data_w = dw; i_len_log = ln;
    chk("ready_idle", 32'(o_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(exp);
    @(negedge clk);
    // Keep offering different operands while busy; they must be ignored.
    i_data_i = ~di; i_data_w = ~dw; i_len_log = 4'd1;
    lat = 1; busy = 0; dw_ok = 1'b1;
    while (!o_valid && lat < LIMIT) begin
      if (o_busy) busy++;
      if (o_data_w !== dw[14:0]) dw_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    i_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy), 32'(exp_busy));
    chk("data_w_held", 32'(dw_ok), 32'd1);
    first = o_prod;
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!(o_valid === 1'b1 && o_prod === first && o_ready === 1'b0)) hold_ok = 1'b0;
    end
    if (hold > 0) chk("backpressure_hold", 32'(hold_ok), 32'd1);
    expq = sb_q.pop_front();
    chk("prod", 32'(o_prod), 32'(expq));
    $display("op di=%h dw=%h len=%0d prod=%h exp=%h lat=%0d", di, dw, ln, o_prod, expq, lat);
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    chk("ready_after_ack", 32'(o_ready), 32'd1);
    chk("valid_after_ack", 32'(o_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_bit_i"}, 32'(o_bit_i), 32'd0);
    chk({tag, "_data_w"}, 32'(o_data_w), 32'd0);
    chk({tag, "_randW"}, 32'(o_randW), 32'd0);
    chk({tag, "_prod"}, 32'(o_prod), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    logic [15:0] rdi, rdw;
    logic [3:0]  rln;

    vecs[0] = '{16'h4000, 16'h4000, 4'd4,  16'h2000, 10};
    vecs[1] = '{16'hC000, 16'h4000, 4'd15, 16'hA000, 0};
    vecs[2] = '{16'h7FFF, 16'h0000, 4'd4,  16'h0000, 0};
    vecs[3] = '{16'h8000, 16'h4000, 4'd4,  16'h0000, 0};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 4'd0,  16'h0000, 0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 4'd4,  16'hF800, 3};
    vecs[6] = '{16'hA000, 16'hE000, 4'd3,  16'h2000, 0};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 4'd2,  16'h6000, 0};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_data_i = '0; i_data_w = '0; i_len_log = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++)
      do_op(vecs[k].di, vecs[k].dw, vecs[k].ln, vecs[k].prod, vecs[k].hold);

    for (int k = 0; k < 4; k++) begin
      rdi = 16'($urandom);
      rdw = 16'($urandom);
      rln = 4'($urandom_range(0, 6));
      do_op(rdi, rdw, rln, ref_prod(rdi, rdw, rln), 0);
    end

    // Reset in the middle of a RUN must abort without ever producing a result.
    @(negedge clk);
    i_valid = 1'b1; i_data_i = 16'h4000; i_data_w = 16'h4000; i_len_log = 4'd4;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_valid) seen_valid = 1'b1;
    end
    chk("no_valid_after_abort", 32'(seen_valid), 32'd0);
    chk("ready_after_abort", 32'(o_ready), 32'd1);
    $display("reset mid-run abort checked");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ut_mul_seq.md
Name: ut_mul_seq

Overview:
Sequencer for one unary-temporal multiply on the 16-bit PE (sign-magnitude, WIDTH-1 magnitude bits).
- Per operation it accepts an input/weight pair and drives the PE with a temporal (thermometer) input bit and the weight magnitude.
- It generates the PE weight random sequence and counts the PE output ones over a 2^len-cycle stream.
- It returns the signed product.
- Sits between the operand feeder and a single mul_inner-style PE.

Parameters:
WIDTH, 16, operand width incl. sign bit; magnitude is WIDTH-1 bits.
LEN_W, 4, width of stream-length log field.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
i_valid  in  1  operand pair valid
o_ready  out  1  block can accept operands
i_data_i  in  WIDTH  input operand, sign-magnitude
i_data_w  in  WIDTH  weight operand, sign-magnitude
i_len_log  in  LEN_W  stream length = 2^len cycles; values >WIDTH-1 clamp to WIDTH-1
o_bit_i  out  1  temporal input bit to PE
o_data_w  out  WIDTH-1  weight magnitude to PE
o_randW  out  WIDTH-1  random value to PE (PE registers it internally, 1 cycle)
i_bit_o  in  1  PE output bit (combinational from PE)
o_valid  out  1  product valid
i_ready  in  1  consumer accepts product
o_prod  out  WIDTH  signed product, sign-magnitude
o_busy  out  1  high in PRIME/RUN

Behaviour:
- Clocking: one clock, clk; reset asynchronous active-low on rst_n. Reset returns to IDLE from any state, aborting any in-flight operation without output.
- Reset values: o_ready=1, o_valid=0, o_bit_i=0, o_data_w=0, o_randW=0, o_prod=0, o_busy=0; counters and accumulator 0.
- IDLE: o_ready=1. On i_valid & o_ready, latch:
  - mi, mw = magnitudes
  - sgn = sign_i ^ sign_w
  - len = clamp(i_len_log)
  - Clear cnt and acc. Go to PRIME.
- PRIME (1 cycle): o_randW = bitrev(0), o_bit_i=0. Compensates the PE randW register. Go to RUN.
- RUN (exactly 2^len cycles, cnt = 0..2^len-1):
  - o_bit_i = (cnt < (mi >> (WIDTH-1-len))).
  - o_randW = bitrev(cnt+1), a WIDTH-1 bit reversal of the counter. The PE therefore compares against bitrev(cnt) in the same cycle as o_bit_i for cnt.
  - acc += i_bit_o each cycle.
  - After the last cnt, go to DONE. o_bit_i=0 outside RUN.
- o_data_w = mw, held from accept until return to IDLE.
- DONE:
  - o_valid=1.
  - o_prod = {sgn', acc << (WIDTH-1-len)}. acc is WIDTH bits; the shifted value saturates to 2^(WIDTH-1)-1.
  - sgn' = 0 when the magnitude is 0.
  - o_prod holds stable until i_ready. On i_valid? ignored; on o_valid & i_ready go to IDLE (o_ready rises next cycle).
- Latency: accept → o_valid = 2^len + 2 cycles.
- Backpressure: DONE holds indefinitely. i_valid is ignored outside IDLE.
- len=0: one RUN cycle; o_bit_i = (0 < mi>>(WIDTH-1)) = 0 for all legal mi, so product is 0.

Optional Feature:
UT_ZERO_SKIP_EN:
- Defined: if mi==0 or mw==0 at accept, skip PRIME/RUN and go directly to DONE with o_prod=0 (latency 1).
- Undefined: zero operands run the full stream (result still 0).

Decomposition:
- Package ut_mul_pkg:
  - state enum {IDLE, PRIME, RUN, DONE}
  - localparams MAG_W=WIDTH-1, ACC_W=WIDTH
  - bitrev function
  - len clamp function
- Sub-module ut_rng_bitrev: counter plus bit-reversal generator with load/clear and enable, output registered. Keeps the generator swappable for sobol16 later.

Test Plan:
- Reset mid-RUN: accept, deassert rst_n at cycle 5 → all outputs at reset values immediately; o_ready=1 after release; no o_valid.
- i_data_i=0x4000 (+16384), i_data_w=0x4000, len=4 → RUN 16 cycles, acc=4, o_prod=0x2000 (+8192), o_valid at cycle 18 after accept.
- i_data_i=0xC000 (−16384), i_data_w=0x4000, len=15 → 32768 RUN cycles, o_prod=0xA000 (−8192).
- i_data_i=0x7FFF, i_data_w=0x0000, len=4 → o_prod=0x0000 (sign 0); with UT_ZERO_SKIP_EN, o_valid 1 cycle after accept.
- Backpressure: hold i_ready=0 for 10 cycles in DONE → o_prod/o_valid stable, o_ready=0; i_ready=1 → o_ready=1 next cycle.
- i_len_log=15 with LEN_W=4 and i_len_log clamp check (e.g. forcing 15 for WIDTH=8) → RUN length 2^(WIDTH-1).
